// File: rtl/if_stage_fifo_pkg.sv
// -----------------------------------------------------------------------------
// if_stage_fifo_pkg
// Shared definitions for the instruction-fetch stage and its fetch queue:
// default pc/instruction widths and queue depth, the width of the IF->ID bus
// ({pc, inst}), and the reset value of each half of that bus.
// -----------------------------------------------------------------------------
package if_stage_fifo_pkg;

    localparam int DEF_PC_W   = 32;
    localparam int DEF_INST_W = 32;
    localparam int DEF_DEPTH  = 4;

    // Reset value of the IF->ID bus, split into its pc and instruction halves.
    localparam logic [DEF_PC_W-1:0]   PC_RST   = '0;
    localparam logic [DEF_INST_W-1:0] INST_RST = '0;

    // Width of the {pc, inst} bus handed to ID.
    function automatic int if_to_id_bus_w(input int pc_w, input int inst_w);
        return pc_w + inst_w;
    endfunction

endpackage

// File: rtl/if_fetch_queue.sv
// -----------------------------------------------------------------------------
// if_fetch_queue
// In-order storage for fetched instructions. Each entry holds {pc, inst,
// filled}. Three pointers, each one bit wider than the index so that full and
// empty can be told apart:
//   alloc - next entry to reserve when a request is accepted (push)
//   fill  - next entry to receive returned instruction data (fill)
//   head  - oldest entry, presented to ID (pop)
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   push, push_pc       reserve entry[alloc] for push_pc
//   fill, fill_inst     write entry[fill].inst and mark it filled
//   pop                 retire entry[head]
//   clear               drop every entry; all pointers collapse onto fill
//   count               alloc - head (entries reserved or buffered)
//   outstanding         alloc - fill (requests still awaiting data)
//   head_filled/pc/inst contents of the head entry
// -----------------------------------------------------------------------------
module if_fetch_queue
    import if_stage_fifo_pkg::*;
#(
    parameter int PC_W   = DEF_PC_W,
    parameter int INST_W = DEF_INST_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [PC_W-1:0]   push_pc,
    input  logic              fill,
    input  logic [INST_W-1:0] fill_inst,
    input  logic              pop,
    input  logic              clear,
    output logic [PTR_W:0]    count,
    output logic [PTR_W:0]    outstanding,
    output logic              head_filled,
    output logic [PC_W-1:0]   head_pc,
    output logic [INST_W-1:0] head_inst
);

    logic [PTR_W:0]    alloc_ptr;
    logic [PTR_W:0]    fill_ptr;
    logic [PTR_W:0]    head_ptr;
    logic [PC_W-1:0]   pc_q   [DEPTH];
    logic [INST_W-1:0] inst_q [DEPTH];
    logic [DEPTH-1:0]  filled_q;

    logic [PTR_W-1:0]  alloc_idx;
    logic [PTR_W-1:0]  fill_idx;
    logic [PTR_W-1:0]  head_idx;

    assign alloc_idx = alloc_ptr[PTR_W-1:0];
    assign fill_idx  = fill_ptr[PTR_W-1:0];
    assign head_idx  = head_ptr[PTR_W-1:0];

    assign count       = alloc_ptr - head_ptr;
    assign outstanding = alloc_ptr - fill_ptr;
    assign head_filled = filled_q[head_idx];
    assign head_pc     = pc_q[head_idx];
    assign head_inst   = inst_q[head_idx];

    // Push, fill and pop touch different entries whenever the caller obeys
    // the protocol (fill never runs ahead of alloc, a full queue takes no
    // push, and the head can only be popped once filled, so it is never the
    // fill target), so the three updates are written independently.
    // Entry data is reset as well so the bus to ID reads zero after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            filled_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= PC_W'(PC_RST);
                inst_q[i] <= INST_W'(INST_RST);
            end
        end else if (clear) begin
            alloc_ptr <= fill_ptr;
            head_ptr  <= fill_ptr;
            filled_q  <= '0;
        end else begin
            if (push) begin
                pc_q[alloc_idx]     <= push_pc;
                filled_q[alloc_idx] <= 1'b0;
                alloc_ptr           <= alloc_ptr + 1'b1;
            end
            if (fill) begin
                inst_q[fill_idx]   <= fill_inst;
                filled_q[fill_idx] <= 1'b1;
                fill_ptr           <= fill_ptr + 1'b1;
            end
            if (pop) begin
                filled_q[head_idx] <= 1'b0;
                head_ptr           <= head_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/if_stage_fifo.sv
// -----------------------------------------------------------------------------
// if_stage_fifo
// Instruction-fetch stage between pre-IF and ID. Accepts PCs from pre-IF,
// issues them on an SRAM-like req/addr_ok/data_ok interface with several
// requests in flight, and buffers the returned {pc, inst} pairs in order so
// ID back-pressure never stalls the memory side. A flush kills everything
// buffered and silently drops responses still owed for killed requests.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   pi_valid_i, pi_pc_i    PC offered by pre-IF
//   if_allowin_o           PC taken this cycle (request handshake fired)
//   inst_sram_req_o        fetch request, address = pi_pc_i
//   inst_sram_addr_o       fetch address
//   inst_sram_addr_ok_i    request accepted by memory
//   inst_sram_rdata_i      returned instruction
//   inst_sram_data_ok_i    response valid, in request order
//   flush_i                pipeline redirect
//   id_allowin_i           ID can accept
//   if_to_id_valid_o       head entry valid for ID
//   to_ifid_obus           {pc, inst} of the head entry
// -----------------------------------------------------------------------------
module if_stage_fifo
    import if_stage_fifo_pkg::*;
#(
    parameter int PC_W   = DEF_PC_W,
    parameter int INST_W = DEF_INST_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     pi_valid_i,
    input  logic [PC_W-1:0]                          pi_pc_i,
    output logic                                     if_allowin_o,
    output logic                                     inst_sram_req_o,
    output logic [PC_W-1:0]                          inst_sram_addr_o,
    input  logic                                     inst_sram_addr_ok_i,
    input  logic [INST_W-1:0]                        inst_sram_rdata_i,
    input  logic                                     inst_sram_data_ok_i,
    input  logic                                     flush_i,
    input  logic                                     id_allowin_i,
    output logic                                     if_to_id_valid_o,
    output logic [if_to_id_bus_w(PC_W, INST_W)-1:0]  to_ifid_obus
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic              started;
    logic [PTR_W:0]    discard_cnt;
    logic [PTR_W:0]    count;
    logic [PTR_W:0]    outstanding;
    logic              head_filled;
    logic [PC_W-1:0]   head_pc;
    logic [INST_W-1:0] head_inst;

    logic              fire;
    logic              keep_resp;
    logic              pop;
    logic              resp_owed;
    logic [PTR_W:0]    fire_inc;
    logic [PTR_W:0]    owed_dec;
    logic [PTR_W:0]    data_dec;

    // A response is only owed to us when some request is still unfilled;
    // a stray data_ok with nothing outstanding is ignored.
    assign resp_owed = (outstanding != '0);

    assign inst_sram_req_o  = started && pi_valid_i && !flush_i
                              && (count != FULL_CNT) && (discard_cnt == '0);
    assign inst_sram_addr_o = pi_pc_i;
    assign fire             = inst_sram_req_o && inst_sram_addr_ok_i;
    assign if_allowin_o     = fire;

    assign keep_resp = inst_sram_data_ok_i && (discard_cnt == '0) && !flush_i
                       && resp_owed;

    assign if_to_id_valid_o = (count != '0) && head_filled && !flush_i;
    assign pop              = if_to_id_valid_o && id_allowin_i;
    assign to_ifid_obus     = {head_pc, head_inst};

    assign fire_inc = {{PTR_W{1'b0}}, fire};
    assign owed_dec = {{PTR_W{1'b0}}, inst_sram_data_ok_i && resp_owed};
    assign data_dec = {{PTR_W{1'b0}}, inst_sram_data_ok_i};

    if_fetch_queue #(
        .PC_W   (PC_W),
        .INST_W (INST_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (fire),
        .push_pc     (pi_pc_i),
        .fill        (keep_resp),
        .fill_inst   (inst_sram_rdata_i),
        .pop         (pop),
        .clear       (flush_i),
        .count       (count),
        .outstanding (outstanding),
        .head_filled (head_filled),
        .head_pc     (head_pc),
        .head_inst   (head_inst)
    );

    // Holds the request line low for the first cycle after reset release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            started <= 1'b0;
        end else begin
            started <= 1'b1;
        end
    end

    // Number of responses still owed for requests killed by a flush. On the
    // first flush it captures every request in flight (less any response
    // arriving in the same cycle); a flush during discard only keeps
    // consuming responses, since no new request can have been issued.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            discard_cnt <= '0;
        end else if (flush_i) begin
            if (discard_cnt != '0) begin
                discard_cnt <= discard_cnt - data_dec;
            end else begin
                discard_cnt <= outstanding + fire_inc - owed_dec;
            end
        end else if ((discard_cnt != '0) && inst_sram_data_ok_i) begin
            discard_cnt <= discard_cnt - 1'b1;
        end
    end

    // Memory must never return data when nothing is outstanding or owed.
    a_no_orphan_data_ok : assert property (
        @(posedge clk) disable iff (!rst_n)
        !(inst_sram_data_ok_i && (discard_cnt == '0) && !resp_owed)
    );

endmodule

// File: tb/tb_if_stage_fifo.sv
// -----------------------------------------------------------------------------
// tb_if_stage_fifo
// Directed and randomised bench for if_stage_fifo. A small memory model
// returns inst = pc ^ 32'h1E80_0000 in request order; every accepted request
// pushes its expected {pc, inst} into a scoreboard which is popped and
// compared whenever ID takes an entry. Flush and reset empty the scoreboard.
// -----------------------------------------------------------------------------
module tb_if_stage_fifo;

    localparam int PC_W   = 32;
    localparam int INST_W = 32;
    localparam int DEPTH  = 4;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     pi_valid_i;
    logic [PC_W-1:0]          pi_pc_i;
    logic                     if_allowin_o;
    logic                     inst_sram_req_o;
    logic [PC_W-1:0]          inst_sram_addr_o;
    logic                     inst_sram_addr_ok_i;
    logic [INST_W-1:0]        inst_sram_rdata_i;
    logic                     inst_sram_data_ok_i;
    logic                     flush_i;
    logic                     id_allowin_i;
    logic                     if_to_id_valid_o;
    logic [PC_W+INST_W-1:0]   to_ifid_obus;

    if_stage_fifo #(
        .PC_W   (PC_W),
        .INST_W (INST_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .pi_valid_i          (pi_valid_i),
        .pi_pc_i             (pi_pc_i),
        .if_allowin_o        (if_allowin_o),
        .inst_sram_req_o     (inst_sram_req_o),
        .inst_sram_addr_o    (inst_sram_addr_o),
        .inst_sram_addr_ok_i (inst_sram_addr_ok_i),
        .inst_sram_rdata_i   (inst_sram_rdata_i),
        .inst_sram_data_ok_i (inst_sram_data_ok_i),
        .flush_i             (flush_i),
        .id_allowin_i        (id_allowin_i),
        .if_to_id_valid_o    (if_to_id_valid_o),
        .to_ifid_obus        (to_ifid_obus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [PC_W-1:0]        mem_q [$];
    logic [PC_W+INST_W-1:0] sb_q  [$];
    logic [PC_W-1:0]        next_pc;
    int                     fire_cnt = 0;
    int                     pop_cnt  = 0;
    int                     pop_base;

    // Values applied to the DUT at the next falling edge.
    logic nv_rst_n = 1'b0;
    logic nv_valid = 1'b0;
    logic nv_flush = 1'b0;
    logic nv_allow = 1'b0;

    // Outputs sampled in the current cycle, 1 time unit after inputs settle.
    logic                   s_req;
    logic                   s_allowin;
    logic                   s_valid;
    logic [PC_W-1:0]        s_addr;
    logic [PC_W+INST_W-1:0] s_bus;

    function automatic logic [INST_W-1:0] mem_inst(input logic [PC_W-1:0] pc);
        return pc ^ 32'h1E80_0000;
    endfunction

    task automatic check_output(input string tag, input logic [63:0] obs,
                                input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs on the falling edge, sample outputs,
    // update the memory model and scoreboard, then wait for the rising edge.
    task automatic apply_stimulus(input logic aok, input logic dok);
        logic dok_eff;
        logic fire;
        logic pop;
        @(negedge clk);
        dok_eff             = dok && (mem_q.size() != 0);
        rst_n               = nv_rst_n;
        pi_valid_i          = nv_valid;
        flush_i             = nv_flush;
        id_allowin_i        = nv_allow;
        pi_pc_i             = next_pc;
        inst_sram_addr_ok_i = aok;
        inst_sram_data_ok_i = dok_eff;
        inst_sram_rdata_i   = dok_eff ? mem_inst(mem_q[0]) : 32'hDEAD_BEEF;
        #1;
        s_req     = inst_sram_req_o;
        s_allowin = if_allowin_o;
        s_valid   = if_to_id_valid_o;
        s_addr    = inst_sram_addr_o;
        s_bus     = to_ifid_obus;
        fire      = s_req && aok;
        pop       = s_valid && id_allowin_i;
        if (rst_n) begin
            if (pop) begin
                if (sb_q.size() == 0) begin
                    check_output("pop_while_empty", 64'(pop), 64'd0);
                end else begin
                    check_output("pop_order", s_bus, sb_q.pop_front());
                end
                pop_cnt++;
            end
            if (fire) begin
                mem_q.push_back(next_pc);
                sb_q.push_back({next_pc, mem_inst(next_pc)});
                next_pc = next_pc + 32'd4;
                fire_cnt++;
            end
            if (dok_eff) begin
                void'(mem_q.pop_front());
            end
            if (flush_i) begin
                sb_q.delete();
            end
        end
        @(posedge clk);
    endtask

    initial begin
        rst_n               = 1'b0;
        pi_valid_i          = 1'b0;
        pi_pc_i             = '0;
        inst_sram_addr_ok_i = 1'b0;
        inst_sram_rdata_i   = '0;
        inst_sram_data_ok_i = 1'b0;
        flush_i             = 1'b0;
        id_allowin_i        = 1'b0;
        next_pc             = 32'h1C00_0000;

        // Reset state, with pre-IF already offering a PC.
        nv_valid = 1'b1;
        apply_stimulus(1'b1, 1'b0);
        check_output("reset_valid", 64'(s_valid), 64'd0);
        check_output("reset_req", 64'(s_req), 64'd0);
        check_output("reset_allowin", 64'(s_allowin), 64'd0);
        check_output("reset_bus", s_bus, 64'd0);
        nv_rst_n = 1'b1;
        apply_stimulus(1'b1, 1'b0);
        check_output("req_before_started", 64'(s_req), 64'd0);

        // Single fetch, data_ok two cycles after addr_ok.
        $display("[TB] single fetch");
        nv_allow = 1'b1;
        apply_stimulus(1'b1, 1'b0);
        check_output("single_req", 64'(s_req), 64'd1);
        check_output("single_allowin", 64'(s_allowin), 64'd1);
        check_output("single_addr", 64'(s_addr), 64'h1C00_0000);
        nv_valid = 1'b0;
        apply_stimulus(1'b0, 1'b0);
        check_output("single_wait_valid", 64'(s_valid), 64'd0);
        apply_stimulus(1'b0, 1'b1);
        check_output("single_no_bypass", 64'(s_valid), 64'd0);
        apply_stimulus(1'b0, 1'b0);
        check_output("single_valid", 64'(s_valid), 64'd1);
        check_output("single_bus", s_bus, 64'h1C00_0000_0280_0000);
        apply_stimulus(1'b0, 1'b0);
        check_output("single_drained", 64'(s_valid), 64'd0);

        // Back-pressure: the queue fills to DEPTH, then drains in order.
        $display("[TB] back-pressure fill");
        nv_allow = 1'b0;
        nv_valid = 1'b1;
        next_pc  = 32'h1C00_0000;
        fire_cnt = 0;
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b1);
        apply_stimulus(1'b1, 1'b1);
        check_output("full_req_low", 64'(s_req), 64'd0);
        apply_stimulus(1'b1, 1'b1);
        check_output("full_fire_count", 64'(fire_cnt), 64'd4);
        nv_allow = 1'b1;
        pop_base = pop_cnt;
        apply_stimulus(1'b0, 1'b0);
        check_output("full_pop_valid", 64'(s_valid), 64'd1);
        check_output("full_pop_same_cycle_req", 64'(s_req), 64'd0);
        apply_stimulus(1'b0, 1'b0);
        check_output("full_req_resumes", 64'(s_req), 64'd1);
        apply_stimulus(1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        check_output("full_pop_count", 64'(pop_cnt - pop_base), 64'd4);
        apply_stimulus(1'b0, 1'b0);
        check_output("full_drained", 64'(s_valid), 64'd0);
        nv_valid = 1'b0;

        // Flush with two requests outstanding and one entry buffered.
        $display("[TB] flush with outstanding requests");
        nv_allow = 1'b0;
        nv_valid = 1'b1;
        next_pc  = 32'h1C00_0200;
        apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b1);
        apply_stimulus(1'b1, 1'b0);
        check_output("flush_buffered_valid", 64'(s_valid), 64'd1);
        nv_flush = 1'b1;
        next_pc  = 32'h1C00_0100;
        apply_stimulus(1'b1, 1'b0);
        check_output("flush_valid_drop", 64'(s_valid), 64'd0);
        check_output("flush_req_low", 64'(s_req), 64'd0);
        nv_flush = 1'b0;
        apply_stimulus(1'b1, 1'b1);
        check_output("discard1_req_low", 64'(s_req), 64'd0);
        check_output("discard1_valid", 64'(s_valid), 64'd0);
        apply_stimulus(1'b1, 1'b1);
        check_output("discard2_req_low", 64'(s_req), 64'd0);
        apply_stimulus(1'b1, 1'b0);
        check_output("redirect_req", 64'(s_req), 64'd1);
        check_output("redirect_addr", 64'(s_addr), 64'h1C00_0100);
        nv_valid = 1'b0;
        apply_stimulus(1'b0, 1'b1);
        nv_allow = 1'b1;
        apply_stimulus(1'b0, 1'b0);
        check_output("redirect_valid", 64'(s_valid), 64'd1);
        check_output("redirect_bus", s_bus, 64'h1C00_0100_0280_0100);
        apply_stimulus(1'b0, 1'b0);

        // Flush coinciding with the only outstanding response.
        $display("[TB] flush with coincident data_ok");
        nv_valid = 1'b1;
        next_pc  = 32'h1C00_0300;
        apply_stimulus(1'b1, 1'b0);
        nv_flush = 1'b1;
        next_pc  = 32'h1C00_0400;
        apply_stimulus(1'b0, 1'b1);
        check_output("flushdok_req_low", 64'(s_req), 64'd0);
        nv_flush = 1'b0;
        apply_stimulus(1'b1, 1'b0);
        check_output("flushdok_req_next", 64'(s_req), 64'd1);
        check_output("flushdok_addr", 64'(s_addr), 64'h1C00_0400);
        nv_valid = 1'b0;
        apply_stimulus(1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b0);
        check_output("flushdok_valid", 64'(s_valid), 64'd1);
        check_output("flushdok_bus", s_bus, 64'h1C00_0400_0280_0400);
        apply_stimulus(1'b0, 1'b0);

        // Pointer wrap: 20 fetches with random handshake stalls.
        $display("[TB] random stalls with pointer wrap");
        next_pc  = 32'h1C00_1000;
        fire_cnt = 0;
        pop_base = pop_cnt;
        nv_valid = 1'b1;
        for (int i = 0; i < 600 && (pop_cnt - pop_base) < 20; i++) begin
            nv_allow = ($urandom_range(0, 3) != 0);
            apply_stimulus(($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)));
            if (fire_cnt >= 20) nv_valid = 1'b0;
        end
        nv_valid = 1'b0;
        check_output("wrap_pop_count", 64'(pop_cnt - pop_base), 64'd20);
        check_output("wrap_fire_count", 64'(fire_cnt), 64'd20);
        check_output("wrap_sb_empty", 64'(sb_q.size()), 64'd0);
        check_output("wrap_mem_empty", 64'(mem_q.size()), 64'd0);

        // Reset with three requests outstanding.
        $display("[TB] reset mid-operation");
        nv_allow = 1'b0;
        nv_valid = 1'b1;
        next_pc  = 32'h1C00_2000;
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0);
        nv_rst_n = 1'b0;
        apply_stimulus(1'b0, 1'b0);
        mem_q.delete();
        sb_q.delete();
        nv_rst_n = 1'b1;
        apply_stimulus(1'b1, 1'b0);
        check_output("rst_mid_valid", 64'(s_valid), 64'd0);
        check_output("rst_mid_req", 64'(s_req), 64'd0);
        check_output("rst_mid_allowin", 64'(s_allowin), 64'd0);
        check_output("rst_mid_bus", s_bus, 64'd0);
        apply_stimulus(1'b1, 1'b0);
        check_output("rst_mid_first_req", 64'(s_req), 64'd1);
        check_output("rst_mid_first_addr", 64'(s_addr), 64'h1C00_200C);
        nv_valid = 1'b0;
        apply_stimulus(1'b0, 1'b1);
        nv_allow = 1'b1;
        apply_stimulus(1'b0, 1'b0);
        check_output("rst_mid_valid_after", 64'(s_valid), 64'd1);
        check_output("rst_mid_bus_after", s_bus, 64'h1C00_200C_0280_200C);
        apply_stimulus(1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage_fifo.md
Name: if_stage_fifo

Overview:
- Parametrised instruction-fetch stage sitting between pre-IF (PC generation) and ID.
- Issues fetch requests on an SRAM-like interface (req/addr_ok/data_ok) and tolerates multi-cycle latency with several requests outstanding.
- Buffers returned {pc, inst} pairs in an in-order FIFO, so ID back-pressure does not stall the memory side.
- On flush, drops buffered entries and discards in-flight responses.

Parameters:
- PC_W, 32, PC width
- INST_W, 32, instruction width
- DEPTH, 4, FIFO entries (power of 2, ≥2); also the maximum outstanding requests plus buffered instructions
- PTR_W, $clog2(DEPTH), pointer width (derived)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- pi_valid_i  in  1  pre-IF presents a valid PC
- pi_pc_i  in  PC_W  PC to fetch
- if_allowin_o  out  1  PC accepted this cycle (request handshake fired)
- inst_sram_req_o  out  1  fetch request
- inst_sram_addr_o  out  PC_W  fetch address (= pi_pc_i)
- inst_sram_addr_ok_i  in  1  request accepted
- inst_sram_rdata_i  in  INST_W  returned instruction
- inst_sram_data_ok_i  in  1  response valid (in request order)
- flush_i  in  1  pipeline redirect; kill all fetched/in-flight work
- id_allowin_i  in  1  ID can accept
- if_to_id_valid_o  out  1  head entry valid for ID
- to_ifid_obus  out  PC_W+INST_W  {pc, inst} of head entry

Behaviour:
- Storage: DEPTH entries, each holding {pc, inst, filled}. Three PTR_W+1 pointers:
  - alloc: advances on addr_ok
  - fill: advances on a kept data_ok
  - head: advances on pop
- count = alloc − head (modulo 2^(PTR_W+1)).
- inst_sram_req_o = pi_valid_i && !flush_i && count < DEPTH && discard_cnt == 0.
- Request fire = req && addr_ok. On fire: entry[alloc] ← {pi_pc_i, filled=0}, alloc++. if_allowin_o = fire (combinational).
- Kept response: data_ok && discard_cnt == 0 && !flush_i. Then entry[fill].inst ← rdata, filled=1, fill++.
- data_ok with fill == alloc and discard_cnt == 0 is a protocol error. Assert in simulation; RTL ignores it.
- if_to_id_valid_o = count ≠ 0 && entry[head].filled && !flush_i. to_ifid_obus = {entry[head].pc, entry[head].inst}.
- Pop = if_to_id_valid_o && id_allowin_i. Clears entry[head].filled; head++.
- Latency: addr_ok at cycle N, data_ok at cycle M ≥ N+1 → entry visible to ID at M+1. No data_ok→ID bypass.
- Simultaneous push, fill and pop in one cycle are all legal and independent.
- Full (count == DEPTH): req held low. A pop in the same cycle does not re-enable req until the next cycle.
- Flush, at the clock edge:
  - discard_cnt ← (alloc − fill) + (fire ? 1 : 0) − (data_ok ? 1 : 0).
  - alloc, fill, head all ← fill's post-flush value (0 is acceptable: all three reset to 0). All filled bits cleared.
  - During the flush cycle, req is low, so fire = 0 and the formula reduces accordingly. addr_ok from the previous request is not re-counted.
- Discard: while discard_cnt ≠ 0, each data_ok decrements it and the data is dropped; req stays low. Fetching resumes the cycle after discard_cnt reaches 0.
- Flush while discard_cnt ≠ 0: discard_cnt ← discard_cnt − data_ok. No new requests can exist.
- Pointer wrap: the extra MSB distinguishes full from empty. Wrap at DEPTH is silent.
- Reset (rst_n=0 at a clock edge): all pointers 0, discard_cnt 0, all filled 0.
  - Outputs: if_to_id_valid_o=0, inst_sram_req_o=0 (gated by a reset-registered "started" flag set one cycle after reset release), if_allowin_o=0, to_ifid_obus=0 (head entry data reset to 0).
  - Reset mid-operation abandons in-flight requests. The memory side must also be reset.

Decomposition:
- Shared package/header: PC_W, INST_W, the IfToIdBus width macro (PC_W+INST_W), and the reset value of the fetch bus.
- One natural sub-module: if_fetch_queue, holding the entries and the three pointers with push/fill/pop/clear ports.
- The top-level holds request gating, flush/discard counter and ID handshake.

Test Plan:
- Single fetch: pi_pc=0x1C000000, addr_ok same cycle, data_ok 2 cycles later with 0x02800000 → valid one cycle after data_ok, bus={0x1C000000,0x02800000}, popped with id_allowin=1.
- Back-pressure fill: id_allowin=0, addr_ok/data_ok every cycle from PC 0x1C000000 +4 → exactly 4 requests issued, req low at count=4. Release id_allowin → 4 pops in order 0x..00,04,08,0C, then fetch resumes.
- Flush with 2 outstanding and 1 buffered: assert flush_i → valid drops immediately, discard_cnt=2. Next two data_ok are dropped with no request issued. Request from new PC 0x1C000100 appears the cycle after the 2nd data_ok.
- Flush coinciding with data_ok, 1 outstanding → discard_cnt=0, next cycle req asserts for the new PC.
- Pointer wrap: 20 sequential fetches with random addr_ok/data_ok/id_allowin stalls → in-order PCs, no loss or duplication (scoreboard).
- Reset asserted with 3 outstanding → next cycle valid=0, req=0, bus=0. After release, the first request appears after the started flag sets.
